// File: rtl/alarm_dismiss_challenge_if.sv
// rtl/alarm_dismiss_challenge_if.sv - signal bundle between alarm logic, keypad, display and challenge block
interface alarm_dismiss_challenge_if #(
    parameter int DIGITS = 4
);
    logic                  alarm_trig;
    logic [4*DIGITS-1:0]   rnd_bus;
    logic                  key_valid;
    logic [3:0]            key_data;
    logic                  buzzer;
    logic                  disp_en;
    logic [4*DIGITS-1:0]   disp_code;
    logic [3:0]            entry_idx;
    logic [2:0]            fail_count;
    logic                  dismissed;

    modport master (
        output alarm_trig, rnd_bus, key_valid, key_data,
        input  buzzer, disp_en, disp_code, entry_idx, fail_count, dismissed
    );

    modport slave (
        input  alarm_trig, rnd_bus, key_valid, key_data,
        output buzzer, disp_en, disp_code, entry_idx, fail_count, dismissed
    );
endinterface

// File: rtl/alarm_dismiss_challenge.sv
// rtl/alarm_dismiss_challenge.sv - random-code challenge that must be re-keyed to silence the alarm
module alarm_dismiss_challenge #(
    parameter int DIGITS        = 4,
    parameter int SHOW_CYCLES   = 50000000,
    parameter int ENTRY_TIMEOUT = 250000000
) (
    input  logic                        clk,
    input  logic                        rst,
    alarm_dismiss_challenge_if.slave    bus
);
    localparam int SW = (SHOW_CYCLES > 1)   ? $clog2(SHOW_CYCLES)   : 1;
    localparam int TW = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, CAPTURE, SHOW, ENTRY, FAIL, DONE} state_t;

    state_t                 state;
    logic                   alarm_d;
    logic                   err;
    logic                   buzzer_q;
    logic                   disp_en_q;
    logic                   dismissed_q;
    logic [DIGITS-1:0][3:0] code_q;
    logic [3:0]             idx_q;
    logic [2:0]             fails_q;
    logic [SW-1:0]          show_cnt;
    logic [TW-1:0]          to_cnt;
    logic [3:0]             cur_digit;
    logic                   mismatch;

    // Mux by compare so a 4-bit index never over-addresses a short code.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 4'(i)) cur_digit = code_q[i];
        end
        mismatch = (bus.key_data != cur_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            alarm_d     <= 1'b0;
            err         <= 1'b0;
            buzzer_q    <= 1'b0;
            disp_en_q   <= 1'b0;
            dismissed_q <= 1'b0;
            code_q      <= '0;
            idx_q       <= 4'd0;
            fails_q     <= 3'd0;
            show_cnt    <= '0;
            to_cnt      <= '0;
        end else begin
            alarm_d <= bus.alarm_trig;
            case (state)
                IDLE: begin
                    if (bus.alarm_trig && !alarm_d) begin
                        fails_q  <= 3'd0;
                        err      <= 1'b0;
                        buzzer_q <= 1'b1;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    code_q    <= bus.rnd_bus;
                    idx_q     <= 4'd0;
                    show_cnt  <= SW'(SHOW_CYCLES - 1);
                    disp_en_q <= 1'b1;
                    state     <= SHOW;
                end
                SHOW: begin
                    if (show_cnt == '0) begin
                        disp_en_q <= 1'b0;
                        to_cnt    <= '0;
                        state     <= ENTRY;
                    end else begin
                        show_cnt <= show_cnt - SW'(1);
                    end
                end
                ENTRY: begin
                    // A key on the final timeout cycle takes priority over expiry.
                    if (bus.key_valid) begin
                        err <= err | mismatch;
                        if (idx_q == 4'(DIGITS - 1)) begin
                            if (err || mismatch) begin
                                state <= FAIL;
                            end else begin
                                buzzer_q    <= 1'b0;
                                dismissed_q <= 1'b1;
                                state       <= DONE;
                            end
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            to_cnt <= '0;
                        end
                    end else if (to_cnt == TW'(ENTRY_TIMEOUT - 1)) begin
                        state <= FAIL;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                FAIL: begin
                    if (fails_q != 3'd7) fails_q <= fails_q + 3'd1;
                    err   <= 1'b0;
                    idx_q <= 4'd0;
                    state <= CAPTURE;
                end
                DONE: begin
                    dismissed_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.buzzer     = buzzer_q;
    assign bus.disp_en    = disp_en_q;
    assign bus.dismissed  = dismissed_q;
    assign bus.disp_code  = code_q;
    assign bus.entry_idx  = idx_q;
    assign bus.fail_count = fails_q;
endmodule

// File: tb/tb_alarm_dismiss_challenge.sv
// tb/tb_alarm_dismiss_challenge.sv - self-checking bench for alarm_dismiss_challenge
module tb_alarm_dismiss_challenge;
    localparam int SHOWC = 4;
    localparam int TO    = 10;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_fc = 0;
    logic [3:0] kk [4];
    int         gg [4];
    bit         passed;
    logic [15:0] c;

    alarm_dismiss_challenge_if #(.DIGITS(4)) bif ();

    alarm_dismiss_challenge #(
        .DIGITS(4), .SHOW_CYCLES(SHOWC), .ENTRY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buzzer"}, bif.buzzer, 0);
        chk({tag, "_disp_en"}, bif.disp_en, 0);
        chk({tag, "_dismissed"}, bif.dismissed, 0);
        chk({tag, "_disp_code"}, bif.disp_code, 0);
        chk({tag, "_entry_idx"}, bif.entry_idx, 0);
        chk({tag, "_fail_count"}, bif.fail_count, 0);
    endtask

    task automatic set_keys(input logic [15:0] code, input bit wrong);
        int j;
        for (int i = 0; i < 4; i++) begin
            kk[i] = code[4*i +: 4];
            gg[i] = 0;
        end
        if (wrong) begin
            j = $urandom_range(0, 3);
            kk[j] = kk[j] ^ 4'($urandom_range(1, 15));
        end
    endtask

    task automatic trigger(input logic [15:0] code);
        bif.alarm_trig = 1'b0;
        tick();
        bif.alarm_trig = 1'b1;
        bif.rnd_bus    = code;
        tick();
        exp_fc = 0;
        chk("trig_buzzer", bif.buzzer, 1);
        chk("trig_disp_en", bif.disp_en, 0);
        chk("trig_fail_count", bif.fail_count, 0);
    endtask

    // Entered with the DUT in CAPTURE; returns with it in the first ENTRY cycle.
    task automatic show_phase(input logic [15:0] code, input bit keys_in_show);
        int  n = 0;
        bit  done = 0;
        bif.rnd_bus = code;
        for (int t = 0; t < 20 && !done; t++) begin
            bif.key_valid = keys_in_show;
            bif.key_data  = 4'($urandom);
            tick();
            if (t == 0) bif.rnd_bus = 16'($urandom);
            if (bif.disp_en) n++;
            else done = 1;
        end
        bif.key_valid = 1'b0;
        chk("show_len", n, SHOWC);
        chk("show_code", bif.disp_code, code);
        chk("entry_start_idx", bif.entry_idx, 0);
        chk("entry_buzzer", bif.buzzer, 1);
    endtask

    task automatic fail_tail();
        chk("fail_buzzer", bif.buzzer, 1);
        chk("fail_dismissed", bif.dismissed, 0);
        chk("fail_hold_count", bif.fail_count, exp_fc);
        exp_fc = (exp_fc >= 7) ? 7 : exp_fc + 1;
        tick();
        chk("recap_fail_count", bif.fail_count, exp_fc);
        chk("recap_entry_idx", bif.entry_idx, 0);
        chk("recap_buzzer", bif.buzzer, 1);
    endtask

    task automatic entry_phase(input logic [15:0] code, output bit ok);
        bit timed_out = 0;
        bit match = 1;
        ok = 0;
        for (int i = 0; i < 4 && !timed_out; i++) begin
            int idle = (gg[i] >= TO) ? TO : gg[i];
            for (int t = 0; t < idle; t++) tick();
            if (gg[i] >= TO) begin
                timed_out = 1;
            end else begin
                bif.key_valid = 1'b1;
                bif.key_data  = kk[i];
                tick();
                bif.key_valid = 1'b0;
                bif.key_data  = 4'($urandom);
                if (kk[i] != code[4*i +: 4]) match = 0;
                if (i < 3) chk("entry_idx_step", bif.entry_idx, i + 1);
            end
        end
        if (!timed_out && match) begin
            chk("done_dismissed", bif.dismissed, 1);
            chk("done_buzzer", bif.buzzer, 0);
            chk("done_fail_count", bif.fail_count, exp_fc);
            chk("done_entry_idx", bif.entry_idx, 3);
            tick();
            chk("idle_dismissed", bif.dismissed, 0);
            chk("idle_buzzer", bif.buzzer, 0);
            chk("idle_code_hold", bif.disp_code, code);
            ok = 1;
        end else begin
            fail_tail();
        end
    endtask

    task automatic attempt(input logic [15:0] code, input bit keys_in_show, output bit ok);
        show_phase(code, keys_in_show);
        entry_phase(code, ok);
    endtask

    initial begin
        rst            = 1'b1;
        bif.alarm_trig = 1'b0;
        bif.key_valid  = 1'b0;
        bif.key_data   = 4'd0;
        bif.rnd_bus    = 16'h0;
        repeat (3) tick();
        chk_all_zero("reset");

        rst            = 1'b0;
        bif.alarm_trig = 1'b1;
        bif.rnd_bus    = 16'h3A07;
        tick();
        chk("release_trig_buzzer", bif.buzzer, 1);
        exp_fc = 0;

        set_keys(16'h3A07, 0);
        attempt(16'h3A07, 0, passed);

        for (int t = 0; t < 3; t++) begin
            tick();
            chk("held_trig_idle", bif.buzzer, 0);
        end

        trigger(16'h3A07);
        kk[0] = 4'h7; kk[1] = 4'h1; kk[2] = 4'hA; kk[3] = 4'h3;
        gg[0] = 0; gg[1] = 0; gg[2] = 0; gg[3] = 0;
        attempt(16'h3A07, 0, passed);
        set_keys(16'h1234, 0);
        attempt(16'h1234, 1, passed);

        c = 16'($urandom);
        trigger(c);
        set_keys(c, 0);
        gg[0] = 9; gg[3] = 12;
        attempt(c, 0, passed);
        c = 16'($urandom);
        set_keys(c, 0);
        gg[0] = 10;
        attempt(c, 0, passed);
        c = 16'($urandom);
        set_keys(c, 0);
        attempt(c, 0, passed);

        c = 16'($urandom);
        trigger(c);
        for (int f = 0; f < 9; f++) begin
            set_keys(c, 1);
            attempt(c, 1'($urandom), passed);
            c = 16'($urandom);
        end
        set_keys(c, 0);
        attempt(c, 0, passed);

        c = 16'($urandom);
        trigger(c);
        show_phase(c, 0);
        for (int i = 0; i < 2; i++) begin
            bif.key_valid = 1'b1;
            bif.key_data  = c[4*i +: 4];
            tick();
        end
        bif.key_valid = 1'b0;
        chk("pre_reset_idx", bif.entry_idx, 2);
        rst = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        c = 16'($urandom);
        bif.rnd_bus = c;
        tick();
        chk("post_reset_retrig", bif.buzzer, 1);
        exp_fc = 0;
        set_keys(c, 0);
        attempt(c, 0, passed);
        c = 16'($urandom);
        trigger(c);
        set_keys(c, 0);
        attempt(c, 0, passed);

        for (int a = 0; a < 6; a++) begin
            int nf = $urandom_range(0, 3);
            c = 16'($urandom);
            trigger(c);
            for (int f = 0; f < nf; f++) begin
                set_keys(c, 1);
                if ($urandom_range(0, 1) == 1) begin
                    set_keys(c, 0);
                    gg[$urandom_range(0, 3)] = TO + $urandom_range(0, 3);
                end
                attempt(c, 1'($urandom), passed);
                c = 16'($urandom);
            end
            set_keys(c, 0);
            for (int i = 0; i < 4; i++) gg[i] = $urandom_range(0, TO - 1);
            attempt(c, 1'($urandom), passed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_dismiss_challenge.md
Name: alarm_dismiss_challenge

Overview:
- Consumes the 4-bit outputs of the pseudo-random number generators and turns them into a dismissal challenge for the ringing alarm.
- On an alarm trigger it latches DIGITS random digits, shows them for a fixed time, then blanks the display.
- The user must then re-enter the digits in order. A correct sequence silences the buzzer; a wrong or late sequence draws a fresh challenge.
- Sits between the random generators plus alarm comparator (upstream) and the 7-segment display, buzzer and keypad logic (downstream).

Parameters:
- DIGITS, 4, number of challenge digits (1..8).
- SHOW_CYCLES, 50000000, clock cycles the code stays displayed.
- ENTRY_TIMEOUT, 250000000, maximum idle cycles between keys (or before the first key) in ENTRY.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- alarm_trig  in  1  alarm-match level from the time comparator; only its rising edge starts a challenge.
- rnd_bus  in  4*DIGITS  random digits; digit i = rnd_bus[4i+3:4i].
- key_valid  in  1  one-cycle strobe: a key was pressed.
- key_data  in  4  value of the pressed key.
- buzzer  out  1  alarm sound enable.
- disp_en  out  1  display shows the challenge code.
- disp_code  out  4*DIGITS  latched challenge code.
- entry_idx  out  4  number of digits entered so far in the current attempt.
- fail_count  out  3  failed attempts in the current alarm, saturating at 7.
- dismissed  out  1  one-cycle pulse when the alarm is silenced.

Behaviour:
- **Single clock domain.** All state changes on the posedge of clk. rst is synchronous, active-high and overrides everything, including mid-challenge.
- **Reset values.** state=IDLE; buzzer, disp_en, dismissed = 0; disp_code, entry_idx, fail_count = 0. The edge-detect register alarm_d = 0, so if alarm_trig is high on the first cycle after reset, it counts as a rising edge.
- **Output decoding.** Outputs are Moore-decoded from registered state.
  - buzzer=1 in CAPTURE, SHOW, ENTRY and FAIL.
  - disp_en=1 only in SHOW.
  - dismissed=1 only in DONE.
- **IDLE.** If alarm_trig & ~alarm_d: fail_count<=0 and go to CAPTURE. A held-high alarm_trig never retriggers.
- **CAPTURE** (1 cycle). disp_code<=rnd_bus, entry_idx<=0, go to SHOW.
- **SHOW** (exactly SHOW_CYCLES cycles, counted by a down-counter). key_valid is ignored. At expiry go to ENTRY and clear the timeout counter.
- **ENTRY.**
  - On key_valid: compare key_data with digit entry_idx and OR any mismatch into a sticky err flag. Then:
    - if entry_idx==DIGITS-1: go to FAIL if err|mismatch, else go to DONE;
    - otherwise entry_idx++ and clear the timeout counter.
  - Without a key, the timeout counter increments. After ENTRY_TIMEOUT consecutive key-less cycles, go to FAIL.
  - If a key arrives in the same cycle the timeout would expire, the key wins.
- **FAIL** (1 cycle). fail_count<=min(fail_count+1,7); clear err and entry_idx; go to CAPTURE, which draws a new code.
- **DONE** (1 cycle). Go to IDLE. disp_code and fail_count hold until the next trigger.
- **Ignored events.** key_valid outside ENTRY has no effect. alarm_trig edges outside IDLE are ignored.
- **Latency.**
  - Trigger sampled at edge k: state becomes CAPTURE, buzzer=1.
  - Edge k+1: code latched, disp_en=1.
  - Last correct key sampled at edge m: dismissed=1 and buzzer=0 from edge m.
- **Counter widths.** Counters are sized with $clog2 of their parameter. There is no wrap-around inside a phase.

Test Plan:
1. Hold rst for 3 cycles with alarm_trig=0 -> every output is 0 and state is IDLE. Release with alarm_trig=1 -> CAPTURE next cycle, buzzer=1.
2. With SHOW_CYCLES=4 and rnd_bus=16'h3A07 at capture: disp_en=1 for exactly 4 cycles with disp_code=16'h3A07. Keys 7,0,A,3 -> dismissed pulses one cycle, buzzer=0, fail_count=0, entry_idx steps 0->3.
3. Same code, keys 7,1,A,3 -> FAIL, fail_count=1. A new capture latches rnd_bus=16'h1234 and SHOW repeats. Keys 4,3,2,1 -> dismissed, fail_count stays 1.
4. With ENTRY_TIMEOUT=10 and no keys -> FAIL after exactly 10 ENTRY cycles. Also pulse a key on the 10th cycle -> that key is accepted and entry_idx=1.
5. Keys pressed during SHOW -> ignored, entry_idx=0. alarm_trig held high through DONE -> stays IDLE. Nine consecutive failures -> fail_count saturates at 7.
6. Assert rst during ENTRY with entry_idx=2 -> next cycle IDLE, all outputs 0. alarm_trig still high -> retriggers (alarm_d reset). Low-then-high -> new challenge.
